// File: rtl/sound_pkg.sv
// Shared sound definitions: scheduler state encoding, event codes, note half-periods
// and the four-note jingle table.
package sound_pkg;

    typedef enum logic [1:0] {
        TS_IDLE  = 2'd0,
        TS_TONE  = 2'd1,
        TS_JNOTE = 2'd2
    } ts_state_e;

    typedef enum logic [1:0] {
        EVT_START = 2'd0,
        EVT_ROUND = 2'd1,
        EVT_WIN   = 2'd2,
        EVT_LOSE  = 2'd3
    } evt_e;

    localparam int         HP_W      = 16;
    localparam logic [2:0] NOTE_REST = 3'd4;

    // Half-period in clock cycles for colour codes 0..3, index 0 in the low slice.
    localparam logic [3:0][HP_W-1:0] TONE_HP = {16'd3189, 16'd3792, 16'd4257, 16'd4778};

    // JINGLE[evt][note]; each entry written as {note3, note2, note1, note0}.
    localparam logic [3:0][3:0][2:0] JINGLE = {
        {NOTE_REST, 3'd0, NOTE_REST, 3'd0},   // lose
        {3'd0, 3'd1, 3'd2, 3'd3},             // win
        {NOTE_REST, NOTE_REST, 3'd3, 3'd2},   // round
        {3'd3, 3'd2, 3'd1, 3'd0}              // start
    };

    // Phase counter reload value; rests keep the counter parked at zero.
    function automatic logic [HP_W-1:0] note_reload(input logic [2:0] code);
        if (code >= NOTE_REST) begin
            return '0;
        end
        return TONE_HP[code[1:0]] - HP_W'(1);
    endfunction

endpackage

// File: rtl/tone_scheduler_if.sv
// Request/status bundle between the game logic and the tone scheduler.
interface tone_scheduler_if;
    logic       COLOR_REQ;
    logic [1:0] COLOR;
    logic       EVT_REQ;
    logic [1:0] EVT;
    logic       MUTE;
    logic       SPK;
    logic       BUSY;
    logic       DONE;

    modport master (
        output COLOR_REQ, COLOR, EVT_REQ, EVT, MUTE,
        input  SPK, BUSY, DONE
    );

    modport slave (
        input  COLOR_REQ, COLOR, EVT_REQ, EVT, MUTE,
        output SPK, BUSY, DONE
    );
endinterface

// File: rtl/tone_gen.sv
// Square-wave generator: half-period phase counter with restart, rest and mute handling.
module tone_gen
    import sound_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       restart,
    input  logic       run,
    input  logic [2:0] code,
    input  logic       mute,
    output logic       spk
);

    logic [HP_W-1:0] phase_q;
    logic [2:0]      code_q;
    logic            spk_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            phase_q <= '0;
            code_q  <= NOTE_REST;
            spk_q   <= 1'b0;
        end else if (restart) begin
            code_q  <= code;
            phase_q <= note_reload(code);
            spk_q   <= 1'b0;
        end else if (!run) begin
            phase_q <= '0;
            spk_q   <= 1'b0;
        end else if (code_q < NOTE_REST) begin
            if (phase_q == '0) begin
                spk_q   <= ~spk_q;
                phase_q <= note_reload(code_q);
            end else begin
                phase_q <= phase_q - HP_W'(1);
            end
        end
    end

    // Mute only gates the pin; the waveform keeps running underneath.
    assign spk = spk_q & ~mute;

endmodule

// File: rtl/tone_scheduler.sv
// Tone scheduler: arbitrates colour tones and event jingles onto a single speaker,
// timing every note against a shared tick prescaler.
module tone_scheduler
    import sound_pkg::*;
#(
    parameter int TICK_DIV    = 10000,
    parameter int NOTE_TICKS  = 250,
    parameter int JNOTE_TICKS = 120
) (
    input logic             CLK,
    input logic             RST_N,
    tone_scheduler_if.slave bus
);

    localparam int PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAX_TICKS = (NOTE_TICKS > JNOTE_TICKS) ? NOTE_TICKS : JNOTE_TICKS;
    localparam int DUR_W     = $clog2(MAX_TICKS + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [DUR_W-1:0]   DUR_TONE   = DUR_W'(NOTE_TICKS);
    localparam logic [DUR_W-1:0]   DUR_JNOTE  = DUR_W'(JNOTE_TICKS);

    ts_state_e          state_q, state_d;
    logic [1:0]         note_idx_q, note_idx_d;
    evt_e               evt_q, evt_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic       tick;
    logic       note_end;
    logic       last_note;
    logic       finish;
    logic       col_ok;
    logic       restart;
    logic [2:0] tone_code;

    assign tick      = (presc_q == PRESC_LAST);
    assign note_end  = (state_q != TS_IDLE) && tick && (dur_q == DUR_W'(1));
    assign last_note = (state_q == TS_TONE) || (note_idx_q == 2'd3);
    assign finish    = note_end && last_note;
    // A jingle blocks colour requests until its final note is ending.
    assign col_ok    = bus.COLOR_REQ && ((state_q != TS_JNOTE) || finish);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= TS_IDLE;
            note_idx_q <= 2'd0;
            evt_q      <= EVT_START;
            presc_q    <= '0;
            dur_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            note_idx_q <= note_idx_d;
            evt_q      <= evt_d;
            presc_q    <= presc_d;
            dur_q      <= dur_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        note_idx_d = note_idx_q;
        evt_d      = evt_q;
        presc_d    = presc_q;
        dur_d      = dur_q;
        done_d     = finish;
        restart    = 1'b0;
        tone_code  = JINGLE[evt_q][note_idx_q];

        if (state_q != TS_IDLE) begin
            presc_d = tick ? '0 : presc_q + PRESC_W'(1);
            if (tick) begin
                dur_d = dur_q - DUR_W'(1);
            end
        end

        if (note_end) begin
            if (last_note) begin
                state_d = TS_IDLE;
                presc_d = '0;
                dur_d   = '0;
            end else begin
                note_idx_d = note_idx_q + 2'd1;
                dur_d      = DUR_JNOTE;
                restart    = 1'b1;
                tone_code  = JINGLE[evt_q][note_idx_q + 2'd1];
            end
        end

        // Accepted requests override whatever the running note was about to do.
        if (bus.EVT_REQ) begin
            state_d    = TS_JNOTE;
            evt_d      = evt_e'(bus.EVT);
            note_idx_d = 2'd0;
            presc_d    = '0;
            dur_d      = DUR_JNOTE;
            restart    = 1'b1;
            tone_code  = JINGLE[bus.EVT][0];
        end else if (col_ok) begin
            state_d    = TS_TONE;
            note_idx_d = 2'd0;
            presc_d    = '0;
            dur_d      = DUR_TONE;
            restart    = 1'b1;
            tone_code  = {1'b0, bus.COLOR};
        end

        busy_d = (state_d != TS_IDLE);
    end

    tone_gen u_tone_gen (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .restart (restart),
        .run     (busy_d),
        .code    (tone_code),
        .mute    (bus.MUTE),
        .spk     (bus.SPK)
    );

    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;

endmodule

// File: doc/tone_scheduler.md
# tone_scheduler

Shares the single speaker output between the game's sound requesters: per-colour tones while a colour is shown or pressed, and fixed event jingles for game start, round cleared, game won and game lost. It sits between the game controller / input encoder and the speaker pin. It arbitrates requests by fixed priority, sequences jingle notes from a ROM, times every note against a shared tick prescaler, and drives a square wave.

## Interface
Parameters:
- `TICK_DIV`, default 10000: clock cycles per time tick (1 ms at 10 MHz).
- `NOTE_TICKS`, default 250: length of a colour tone, in ticks.
- `JNOTE_TICKS`, default 120: length of each jingle note, in ticks.

Ports:
- `CLK`, in, 1: clock.
- `RST_N`, in, 1: asynchronous, active-low reset.
- `COLOR_REQ`, in, 1: one-cycle pulse requesting a colour tone.
- `COLOR`, in, 2: colour 0..3; sampled with `COLOR_REQ`.
- `EVT_REQ`, in, 1: one-cycle pulse requesting a jingle.
- `EVT`, in, 2: 0 = start, 1 = round, 2 = win, 3 = lose; sampled with `EVT_REQ`.
- `MUTE`, in, 1: forces `SPK` low; all timing continues unchanged.
- `SPK`, out, 1: square-wave speaker drive.
- `BUSY`, out, 1: high while a tone or jingle is playing.
- `DONE`, out, 1: one-cycle pulse when a tone or jingle completes naturally.

## Operation
- States:
  - `TS_IDLE`: silent.
  - `TS_TONE`: playing a colour tone.
  - `TS_JNOTE`: playing a jingle note.
- Priority: `EVT_REQ` beats `COLOR_REQ`.
  - Simultaneous requests: the event is taken and the colour request is dropped.
- Acceptance and preemption:
  - Any state, `EVT_REQ`: go to `TS_JNOTE` with note index 0 of `JINGLE[EVT]`.
    - This preempts a running tone or restarts a running jingle.
  - `TS_IDLE` or `TS_TONE`, `COLOR_REQ` alone: go to `TS_TONE` with `COLOR`.
    - A running tone restarts with the new colour.
  - `TS_JNOTE`, `COLOR_REQ` alone: ignored and dropped, no queueing.
- On every accepted request:
  - Prescaler and duration counter reload.
  - Phase counter reloads and `SPK` restarts low.
- Note codes are 3 bits: 0..3 are colour tones, 4 is `NOTE_REST`.
  - A rest holds `SPK` low and still consumes its full duration.
- Tone generation: the phase counter loads `TONE_HP[code]-1` and decrements each cycle. At 0 it toggles `SPK` and reloads.
- Jingle sequencing:
  - Each jingle has exactly 4 notes.
  - When a note's duration expires, the note index advances and `SPK` restarts low with the next note.
  - After note 3 the block returns to `TS_IDLE`.
- Completion: `DONE` pulses only on natural completion; a preempted request produces no `DONE`.
- `BUSY` equals (state != `TS_IDLE`), registered.

## Timing
- Reset values: `SPK`=0, `BUSY`=0, `DONE`=0, state `TS_IDLE`, all counters 0.
- Reset asserted mid-note: immediate silence; no `DONE`.
- Request sampled at edge N:
  - From edge N+1: `BUSY`=1 and the new note is active.
  - First `SPK` rise at edge N+1+`TONE_HP[c]`.
  - Period is `2*TONE_HP[c]` cycles.
- Prescaler counts 0..`TICK_DIV-1` and emits a tick on wrap. The duration counter decrements on each tick.
- Note length is exactly `ticks*TICK_DIV` cycles from acceptance or from the previous note's end.
  - Colour tone: `NOTE_TICKS*TICK_DIV` cycles.
  - Jingle: `4*JNOTE_TICKS*TICK_DIV` cycles.
- Last cycle of a note: the `DONE` pulse and `BUSY` falling occur on the same edge, with `SPK` forced 0.
- A request arriving in the completion cycle is accepted. `DONE` still pulses and `BUSY` stays 1.
- Width rules:
  - Prescaler width: `$clog2(TICK_DIV)`.
  - Duration width: `$clog2(max(NOTE_TICKS,JNOTE_TICKS)+1)`.
  - Phase counter width: 16 bits.
  - All counters wrap-free; reloads are explicit.

## Structure
Shared package `sound_pkg` holds:
- state encodings `TS_*`;
- `NOTE_REST`=4;
- `TONE_HP[0..3]` = 4778, 4257, 3792, 3189;
- `JINGLE[0..3][0..3]`:
  - start = 0,1,2,3
  - round = 2,3,REST,REST
  - win = 3,2,1,0
  - lose = 0,REST,0,REST
- event codes `EVT_START`/`EVT_ROUND`/`EVT_WIN`/`EVT_LOSE`.

One sub-module, `tone_gen`, is natural: it holds the phase counter, the `SPK` toggle, and the rest and mute handling, with a restart input.

## Test plan
All scenarios use `TICK_DIV`=4, `NOTE_TICKS`=3, `JNOTE_TICKS`=2.
- `COLOR_REQ` with `COLOR`=2 -> `BUSY` high for 12 cycles; `SPK` period 7584 is never completed, so `SPK` stays 0; `DONE` pulses once at cycle 12.
- Reset, then `EVT_REQ` with `EVT`=3 (lose) -> `BUSY` high for 32 cycles, `SPK` 0 throughout, note index steps every 8 cycles, single `DONE`.
- Both requests in the same cycle -> jingle plays; colour dropped; `BUSY` lasts 32 cycles.
- `COLOR_REQ` at cycle 5 of a running tone -> tone restarts; `BUSY` continuous; one `DONE` at 5+12; no `DONE` at 12.
- `COLOR_REQ` during a jingle -> ignored; `EVT_REQ` during a jingle -> restart at note 0 with no `DONE`.
- `TONE_HP` period check with `TICK_DIV`=10000 and `COLOR`=0: first `SPK` rise 4778 cycles after acceptance, then toggles every 4778 cycles. With `MUTE`=1, `SPK`=0 while `BUSY`/`DONE` timing is identical. Reset asserted mid-tone: `SPK`, `BUSY` and `DONE` go 0 immediately.
